// File: rtl/ovl_fire_collector.sv
// Aggregates {cover,xcheck,2state} fire vectors from a bank of OVL checkers into
// saturating per-checker counters, sticky summary flags and a first-failure record.
module ovl_fire_collector #(
    parameter int num_checkers  = 4,
    parameter int sel_width     = 2,
    parameter int cnt_width     = 8,
    parameter int time_width    = 16,
    parameter int stop_on_first = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [3*num_checkers-1:0] fire_in,
    input  logic                      clear,
    input  logic [sel_width-1:0]      rd_sel,
    output logic [cnt_width-1:0]      rd_fail_count,
    output logic [cnt_width-1:0]      rd_xchk_count,
    output logic [cnt_width-1:0]      cover_count,
    output logic                      any_fail,
    output logic                      any_xcheck,
    output logic [sel_width-1:0]      first_idx,
    output logic [1:0]                first_type,
    output logic [time_width-1:0]     first_time,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        st_idle      = 2'b00,
        st_armed     = 2'b01,
        st_triggered = 2'b10
    } state_t;

    localparam int sum_w = cnt_width + $clog2(num_checkers + 1);
    localparam logic [cnt_width-1:0] cnt_max = '1;
    localparam logic [cnt_width-1:0] cnt_one = {{(cnt_width-1){1'b0}}, 1'b1};

    state_t state_reg, state_next;
    logic   count_en, trigger;

    logic [num_checkers-1:0] fail_vec, xchk_vec, cover_vec, hit_vec;
    logic [num_checkers-1:0][cnt_width-1:0] fail_cnt_reg, fail_cnt_next;
    logic [num_checkers-1:0][cnt_width-1:0] xchk_cnt_reg, xchk_cnt_next;

    logic [cnt_width-1:0]  cover_reg, cover_next;
    logic [sum_w-1:0]      cover_sum, cover_total;
    logic [time_width-1:0] ts_reg;
    logic                  any_fail_reg, any_xcheck_reg;
    logic [sel_width-1:0]  first_idx_reg, trig_idx;
    logic [1:0]            first_type_reg;
    logic [time_width-1:0] first_time_reg;
    logic [cnt_width-1:0]  rd_fail_reg, rd_xchk_reg;
    logic                  rd_valid;

    // Per-checker bit split and saturating increment
    genvar gi;
    generate
        for (gi = 0; gi < num_checkers; gi++) begin : g_chk
            assign fail_vec[gi]  = fire_in[3*gi];
            assign xchk_vec[gi]  = fire_in[3*gi+1];
            assign cover_vec[gi] = fire_in[3*gi+2];
            assign hit_vec[gi]   = fire_in[3*gi] | fire_in[3*gi+1];
            assign fail_cnt_next[gi] = (count_en && fail_vec[gi] && fail_cnt_reg[gi] != cnt_max)
                                       ? fail_cnt_reg[gi] + cnt_one : fail_cnt_reg[gi];
            assign xchk_cnt_next[gi] = (count_en && xchk_vec[gi] && xchk_cnt_reg[gi] != cnt_max)
                                       ? xchk_cnt_reg[gi] + cnt_one : xchk_cnt_reg[gi];
        end
    endgenerate

    always_comb begin
        cover_sum = '0;
        for (int k = 0; k < num_checkers; k++) begin
            cover_sum = cover_sum + sum_w'(cover_vec[k]);
        end
        cover_total = sum_w'(cover_reg) + cover_sum;
        cover_next  = cover_reg;
        if (count_en) begin
            cover_next = (cover_total > sum_w'(cnt_max)) ? cnt_max : cover_total[cnt_width-1:0];
        end
    end

    // Lowest failing index wins, so scan from the top down
    always_comb begin
        trig_idx = '0;
        for (int k = num_checkers - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                trig_idx = sel_width'(k);
            end
        end
    end

    assign rd_valid = 32'(rd_sel) < num_checkers;

    always_comb begin
        state_next = state_reg;
        count_en   = 1'b0;
        trigger    = 1'b0;
        if (clear) begin
            state_next = enable ? st_armed : st_idle;
        end else begin
            case (state_reg)
                st_idle: begin
                    if (enable) state_next = st_armed;
                end
                st_armed: begin
                    if (!enable) begin
                        state_next = st_idle;
                    end else begin
                        count_en = 1'b1;
                        if (|hit_vec) begin
                            trigger    = 1'b1;
                            state_next = st_triggered;
                        end
                    end
                end
                st_triggered: begin
                    count_en = enable && (stop_on_first == 0);
                end
                default: state_next = st_idle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= st_idle;
            ts_reg         <= '0;
            fail_cnt_reg   <= '0;
            xchk_cnt_reg   <= '0;
            cover_reg      <= '0;
            any_fail_reg   <= 1'b0;
            any_xcheck_reg <= 1'b0;
            first_idx_reg  <= '0;
            first_type_reg <= '0;
            first_time_reg <= '0;
            rd_fail_reg    <= '0;
            rd_xchk_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ts_reg    <= ts_reg + time_width'(1);
            if (clear) begin
                fail_cnt_reg   <= '0;
                xchk_cnt_reg   <= '0;
                cover_reg      <= '0;
                any_fail_reg   <= 1'b0;
                any_xcheck_reg <= 1'b0;
                first_idx_reg  <= '0;
                first_type_reg <= '0;
                first_time_reg <= '0;
                rd_fail_reg    <= '0;
                rd_xchk_reg    <= '0;
            end else begin
                fail_cnt_reg   <= fail_cnt_next;
                xchk_cnt_reg   <= xchk_cnt_next;
                cover_reg      <= cover_next;
                any_fail_reg   <= any_fail_reg | (count_en & (|fail_vec));
                any_xcheck_reg <= any_xcheck_reg | (count_en & (|xchk_vec));
                if (trigger) begin
                    first_idx_reg  <= trig_idx;
                    first_type_reg <= {xchk_vec[trig_idx], fail_vec[trig_idx]};
                    first_time_reg <= ts_reg;
                end
                rd_fail_reg <= rd_valid ? fail_cnt_reg[rd_sel] : '0;
                rd_xchk_reg <= rd_valid ? xchk_cnt_reg[rd_sel] : '0;
            end
        end
    end

    assign rd_fail_count = rd_fail_reg;
    assign rd_xchk_count = rd_xchk_reg;
    assign cover_count   = cover_reg;
    assign any_fail      = any_fail_reg;
    assign any_xcheck    = any_xcheck_reg;
    assign first_idx     = first_idx_reg;
    assign first_type    = first_type_reg;
    assign first_time    = first_time_reg;
    assign state         = state_reg;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed bench for ovl_fire_collector: a cycle model checks the default instance every
// cycle; a stop_on_first / narrow-timestamp instance is pinned with literal expectations.
module tb_ovl_fire_collector;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int TW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [11:0] fire_in;
    logic        clear;
    logic [1:0]  rd_sel;

    logic [7:0]  rd_fail_count, rd_xchk_count, cover_count;
    logic        any_fail, any_xcheck;
    logic [1:0]  first_idx, first_type, state;
    logic [15:0] first_time;

    logic [7:0]  s_rd_fail_count, s_rd_xchk_count, s_cover_count;
    logic        s_any_fail, s_any_xcheck;
    logic [1:0]  s_first_idx, s_first_type, s_state;
    logic [3:0]  s_first_time;

    int n_tests = 0;
    int n_fail  = 0;

    ovl_fire_collector #(.num_checkers(NC), .sel_width(2), .cnt_width(CW),
                         .time_width(TW), .stop_on_first(0)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fire_in(fire_in),
        .clear(clear), .rd_sel(rd_sel),
        .rd_fail_count(rd_fail_count), .rd_xchk_count(rd_xchk_count),
        .cover_count(cover_count), .any_fail(any_fail), .any_xcheck(any_xcheck),
        .first_idx(first_idx), .first_type(first_type), .first_time(first_time),
        .state(state)
    );

    ovl_fire_collector #(.num_checkers(NC), .sel_width(2), .cnt_width(CW),
                         .time_width(4), .stop_on_first(1)) dut_s (
        .clock(clock), .reset(reset), .enable(enable), .fire_in(fire_in),
        .clear(clear), .rd_sel(rd_sel),
        .rd_fail_count(s_rd_fail_count), .rd_xchk_count(s_rd_xchk_count),
        .cover_count(s_cover_count), .any_fail(s_any_fail), .any_xcheck(s_any_xcheck),
        .first_idx(s_first_idx), .first_type(s_first_type), .first_time(s_first_time),
        .state(s_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the default instance: integer counters and a state code
    int m_state, m_ts, m_cover, m_anyf, m_anyx, m_fidx, m_ftype, m_ftime, m_rdf, m_rdx;
    int m_fail[NC];
    int m_xchk[NC];

    always @(posedge clock) begin
        int ts_old;
        int low;
        if (!reset) begin
            m_state = 0; m_ts = 0; m_cover = 0; m_anyf = 0; m_anyx = 0;
            m_fidx = 0; m_ftype = 0; m_ftime = 0; m_rdf = 0; m_rdx = 0;
            for (int k = 0; k < NC; k++) begin
                m_fail[k] = 0;
                m_xchk[k] = 0;
            end
        end else begin
            ts_old = m_ts;
            m_ts   = (m_ts + 1) % (1 << TW);
            m_rdf  = clear ? 0 : ((int'(rd_sel) < NC) ? m_fail[rd_sel] : 0);
            m_rdx  = clear ? 0 : ((int'(rd_sel) < NC) ? m_xchk[rd_sel] : 0);
            if (clear) begin
                m_cover = 0; m_anyf = 0; m_anyx = 0; m_fidx = 0; m_ftype = 0; m_ftime = 0;
                for (int k = 0; k < NC; k++) begin
                    m_fail[k] = 0;
                    m_xchk[k] = 0;
                end
                m_state = enable ? 1 : 0;
            end else if (enable && m_state != 0) begin
                if (m_state == 1 || 1'b1) begin
                    // default instance keeps counting after the trigger
                    for (int k = 0; k < NC; k++) begin
                        if (fire_in[3*k])   begin m_fail[k] = (m_fail[k] < CMAX) ? m_fail[k] + 1 : CMAX; m_anyf = 1; end
                        if (fire_in[3*k+1]) begin m_xchk[k] = (m_xchk[k] < CMAX) ? m_xchk[k] + 1 : CMAX; m_anyx = 1; end
                        if (fire_in[3*k+2]) m_cover = (m_cover < CMAX) ? m_cover + 1 : CMAX;
                    end
                end
                if (m_state == 1) begin
                    low = -1;
                    for (int k = NC - 1; k >= 0; k--) begin
                        if (fire_in[3*k] || fire_in[3*k+1]) low = k;
                    end
                    if (low >= 0) begin
                        m_fidx  = low;
                        m_ftype = int'(fire_in[3*low]) + 2 * int'(fire_in[3*low+1]);
                        m_ftime = ts_old;
                        m_state = 2;
                    end
                end
            end else if (m_state == 0 && enable) begin
                m_state = 1;
            end else if (m_state == 1 && !enable) begin
                m_state = 0;
            end
        end
        #1;
        check("state",      int'(state),         m_state);
        check("first_idx",  int'(first_idx),     m_fidx);
        check("first_type", int'(first_type),    m_ftype);
        check("first_time", int'(first_time),    m_ftime);
        check("any_fail",   int'(any_fail),      m_anyf);
        check("any_xcheck", int'(any_xcheck),    m_anyx);
        check("cover",      int'(cover_count),   m_cover);
        check("rd_fail",    int'(rd_fail_count), m_rdf);
        check("rd_xchk",    int'(rd_xchk_count), m_rdx);
    end

    initial begin
        reset = 1'b0; enable = 1'b0; fire_in = '0; clear = 1'b0; rd_sel = '0;

        // Reset held 3 cycles with random fires
        repeat (3) begin
            fire_in = 12'($urandom);
            enable  = 1'($urandom);
            @(negedge clock);
        end
        $display("[TB] reset: state=%0d cover=%0d", state, cover_count);
        check("rst state",      int'(state),         0);
        check("rst cover",      int'(cover_count),   0);
        check("rst rd_fail",    int'(rd_fail_count), 0);
        check("rst any_fail",   int'(any_fail),      0);
        check("rst first_time", int'(first_time),    0);
        check("rst s_state",    int'(s_state),       0);

        // Release; arm on first edge, fire checker2 2-state at timestamp 10
        reset = 1'b1; enable = 1'b1; fire_in = '0;
        repeat (10) @(negedge clock);
        fire_in = 12'h040;
        @(negedge clock);
        fire_in = '0;
        $display("[TB] trigger: state=%0d idx=%0d type=%0d time=%0d", state, first_idx, first_type, first_time);
        check("t2 state",      int'(state),      2);
        check("t2 first_idx",  int'(first_idx),  2);
        check("t2 first_type", int'(first_type), 1);
        check("t2 first_time", int'(first_time), 10);
        check("t2 any_fail",   int'(any_fail),   1);
        check("t2 s_time",     int'(s_first_time), 10);

        // Clear with a coincident fire: fire discarded, re-armed
        clear = 1'b1; fire_in = 12'h001;
        @(negedge clock);
        clear = 1'b0;
        $display("[TB] clear: state=%0d any_fail=%0d", state, any_fail);
        check("t5 state",    int'(state),       1);
        check("t5 any_fail", int'(any_fail),    0);
        check("t5 cover",    int'(cover_count), 0);

        // Checkers 1 and 3 both 011 in one cycle at timestamp 12
        fire_in = 12'h618; rd_sel = 2'd3;
        @(negedge clock);
        fire_in = '0;
        $display("[TB] dual fire: idx=%0d type=%0d time=%0d", first_idx, first_type, first_time);
        check("t3 first_idx",  int'(first_idx),  1);
        check("t3 first_type", int'(first_type), 3);
        check("t3 first_time", int'(first_time), 12);
        @(negedge clock);
        $display("[TB] readback chk3: fail=%0d xchk=%0d", rd_fail_count, rd_xchk_count);
        check("t3 rd_fail", int'(rd_fail_count), 1);
        check("t3 rd_xchk", int'(rd_xchk_count), 1);

        // Saturation: checker0 {cover,2state} held 300 sampled cycles from timestamp 16
        clear = 1'b1; rd_sel = 2'd0;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        fire_in = 12'h005;
        repeat (300) @(negedge clock);
        fire_in = '0;
        @(negedge clock);
        $display("[TB] saturate: fail=%0d cover=%0d s_fail=%0d s_cover=%0d",
                 rd_fail_count, cover_count, s_rd_fail_count, s_cover_count);
        check("t4 rd_fail",    int'(rd_fail_count),   255);
        check("t4 cover",      int'(cover_count),     255);
        check("t4 first_time", int'(first_time),      16);
        check("t4 s_rd_fail",  int'(s_rd_fail_count), 1);
        check("t4 s_cover",    int'(s_cover_count),   1);
        check("t4 s_time_wrap", int'(s_first_time),   0);
        check("t4 s_state",    int'(s_state),         2);

        // TRIGGERED ignores enable==0
        enable = 1'b0; fire_in = 12'h002;
        repeat (2) @(negedge clock);
        $display("[TB] triggered/disabled: state=%0d any_xcheck=%0d", state, any_xcheck);
        check("t6 state held", int'(state),      2);
        check("t6 no xcheck",  int'(any_xcheck), 0);

        // Clear while disabled -> IDLE; arm cycle ignores fires; ARMED drops back when disabled
        clear = 1'b1; fire_in = '0;
        @(negedge clock);
        clear = 1'b0;
        check("t6 clr idle", int'(state), 0);
        enable = 1'b1; fire_in = 12'h002;
        @(negedge clock);
        $display("[TB] arm: state=%0d any_xcheck=%0d", state, any_xcheck);
        check("t6 armed",      int'(state),      1);
        check("t6 arm ignore", int'(any_xcheck), 0);
        enable = 1'b0;
        @(negedge clock);
        check("t6 disarm",     int'(state),      0);
        check("t6 disarm ign", int'(any_xcheck), 0);
        fire_in = 12'hFFF;
        repeat (3) @(negedge clock);
        fire_in = '0;
        $display("[TB] idle fires: state=%0d cover=%0d any_fail=%0d", state, cover_count, any_fail);
        check("t6 idle cover", int'(cover_count), 0);
        check("t6 idle fail",  int'(any_fail),    0);
        check("t6 idle state", int'(state),       0);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
